// File: rtl/recorder_burst_writer.sv
// recorder_burst_writer: FIFO-buffered sample stream written to memory as single-outstanding AXI3 INCR bursts.
// Define RECORDER_WRAP_EN for ring-buffer recording between the two addresses (adds the sticky wrapped output).
module recorder_burst_writer #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned BURST_BEATS = 16,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    strobe_in,
  input  logic                    start,
  input  logic                    stop,
  input  logic [ADDR_WIDTH-1:0]   start_address,
  input  logic [ADDR_WIDTH-1:0]   end_address,
  output logic                    finished,
  output logic                    dropped_samples,
  output logic                    write_error,
`ifdef RECORDER_WRAP_EN
  output logic                    wrapped,
`endif
  output logic [ADDR_WIDTH-1:0]   next_address,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SIZE_LOG2  = $clog2(STRB_WIDTH);
  localparam int unsigned PTR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_WIDTH  = PTR_WIDTH + 1;
  localparam int unsigned LEN_WIDTH  = $clog2(BURST_BEATS + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CNT_WIDTH-1:0]  count;
  logic [ADDR_WIDTH-1:0] cur, end_q, cur_inc;
`ifdef RECORDER_WRAP_EN
  logic [ADDR_WIDTH-1:0] start_q;
`endif
  logic [LEN_WIDTH-1:0]  burst_len, beats_left, len_sel;
  logic                  stop_pend;
  logic                  active, start_ok, push, pop, full, wr_en, drop;
  logic                  aw_hs, b_hs, level_full, at_end;

  // Handshake and FIFO decode
  always_comb begin
    active     = (state == S_WAIT) || (state == S_ADDR) || (state == S_DATA) || (state == S_RESP);
    start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
    pop        = wvalid && wready;
    push       = strobe_in && active && !stop_pend;
    full       = (count == CNT_WIDTH'(FIFO_DEPTH));
    wr_en      = push && (!full || pop);
    drop       = push && full && !pop;
    aw_hs      = awvalid && awready;
    b_hs       = bvalid && bready;
    level_full = (count >= CNT_WIDTH'(BURST_BEATS));
    len_sel    = level_full ? LEN_WIDTH'(BURST_BEATS) : LEN_WIDTH'(count);
    rd_ptr_inc = rd_ptr + 1'b1;
    cur_inc    = cur + (ADDR_WIDTH'(burst_len) << SIZE_LOG2);
    at_end     = (cur_inc == end_q);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_WAIT;
      S_WAIT: begin
        if (level_full || (stop_pend && (count != '0))) state_nx = S_ADDR;
        else if (stop_pend)                             state_nx = S_DONE;
      end
      S_ADDR: if (aw_hs) state_nx = S_DATA;
      S_DATA: if (pop && wlast) state_nx = S_RESP;
      S_RESP: begin
        if (b_hs) begin
`ifdef RECORDER_WRAP_EN
          state_nx = S_WAIT;
`else
          state_nx = at_end ? S_DONE : S_WAIT;
`endif
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      cur             <= '0;
      end_q           <= '0;
`ifdef RECORDER_WRAP_EN
      start_q         <= '0;
      wrapped         <= 1'b0;
`endif
      burst_len       <= '0;
      beats_left      <= '0;
      stop_pend       <= 1'b0;
      finished        <= 1'b0;
      dropped_samples <= 1'b0;
      write_error     <= 1'b0;
      next_address    <= '0;
      awaddr          <= '0;
      awlen           <= '0;
      awsize          <= '0;
      awburst         <= '0;
      awcache         <= '0;
      awprot          <= '0;
      awvalid         <= 1'b0;
      wdata           <= '0;
      wstrb           <= '0;
      wlast           <= 1'b0;
      wvalid          <= 1'b0;
      bready          <= 1'b0;
    end else begin
      state    <= state_nx;
      awvalid  <= (state_nx == S_ADDR);
      wvalid   <= (state_nx == S_DATA);
      bready   <= (state_nx == S_RESP);
      finished <= (state_nx == S_DONE);
      awsize   <= 3'(SIZE_LOG2);
      awburst  <= 2'b01;
      awcache  <= 4'b0011;
      awprot   <= 3'b000;
      wstrb    <= '1;

      // FIFO is only live while recording
      if (!active) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr_inc;
        count <= count + CNT_WIDTH'(wr_en) - CNT_WIDTH'(pop);
      end
      if (drop) dropped_samples <= 1'b1;

      if (start_ok) begin
        cur             <= start_address;
        end_q           <= end_address;
        next_address    <= start_address;
        dropped_samples <= 1'b0;
        write_error     <= 1'b0;
        stop_pend       <= stop;
`ifdef RECORDER_WRAP_EN
        start_q         <= start_address;
        wrapped         <= 1'b0;
`endif
      end else if (active && stop) begin
        stop_pend <= 1'b1;
      end

      if ((state == S_WAIT) && (state_nx == S_ADDR)) begin
        burst_len <= len_sel;
        awaddr    <= cur;
        awlen     <= 4'(len_sel - 1'b1);
      end

      // wdata is prefetched so the head word is registered before each beat
      if (aw_hs) begin
        wdata      <= mem[rd_ptr];
        wlast      <= (burst_len == LEN_WIDTH'(1));
        beats_left <= burst_len;
      end else if (pop) begin
        beats_left <= beats_left - 1'b1;
        wlast      <= (beats_left == LEN_WIDTH'(2));
        if (!wlast) wdata <= mem[rd_ptr_inc];
      end

      if (b_hs) begin
        if (bresp != 2'b00) write_error <= 1'b1;
`ifdef RECORDER_WRAP_EN
        if (at_end) begin
          cur          <= start_q;
          next_address <= start_q;
          wrapped      <= 1'b1;
        end else begin
          cur          <= cur_inc;
          next_address <= cur_inc;
        end
`else
        cur          <= cur_inc;
        next_address <= cur_inc;
`endif
      end
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_recorder_burst_writer.sv
// Directed bench for recorder_burst_writer: AXI slave model, burst monitor and hand-computed expectations.
module tb_recorder_burst_writer;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          strobe_in, start, stop;
  logic [AW-1:0] start_address, end_address;
  logic          finished, dropped_samples, write_error;
`ifdef RECORDER_WRAP_EN
  logic          wrapped;
`endif
  logic [AW-1:0] next_address, awaddr;
  logic [3:0]    awlen, awcache;
  logic [2:0]    awsize, awprot;
  logic [1:0]    awburst, bresp;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wlast, wvalid, wready, bvalid, bready;

  logic          aw_stall;
  logic [1:0]    bresp_val;

  recorder_burst_writer #(
    .DATA_WIDTH(DW), .BURST_BEATS(16), .FIFO_DEPTH(64), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .strobe_in(strobe_in),
    .start(start), .stop(stop), .start_address(start_address), .end_address(end_address),
    .finished(finished), .dropped_samples(dropped_samples), .write_error(write_error),
`ifdef RECORDER_WRAP_EN
    .wrapped(wrapped),
`endif
    .next_address(next_address),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  assign awready = !aw_stall;
  assign wready  = 1'b1;
  assign bvalid  = bready;
  assign bresp   = bresp_val;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: records every handshake that will complete on the next rising edge
  logic [AW-1:0] aw_addr_q[$];
  logic [3:0]    aw_len_q[$];
  logic [DW-1:0] w_data_q[$];
  logic          w_last_q[$];
  int            b_cnt = 0;
  int            proto_err = 0;
  bit            aw_open = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      aw_open = 1'b0;
    end else begin
      if (awvalid && aw_open) proto_err++;
      if (wvalid && !aw_open) proto_err++;
      if (awvalid && awready) begin
        aw_addr_q.push_back(awaddr);
        aw_len_q.push_back(awlen);
        aw_open = 1'b1;
      end
      if (wvalid && wready) begin
        w_data_q.push_back(wdata);
        w_last_q.push_back(wlast);
      end
      if (bvalid && bready) begin
        b_cnt++;
        aw_open = 1'b0;
      end
    end
  end

  function automatic logic [DW-1:0] word(input int scn, input int idx);
    return {16'hC0DE, 16'(scn), 32'(idx)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic do_start(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
    start_address = sa;
    end_address   = ea;
    start         = 1'b1;
    step();
    start         = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic push_words(input int scn, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      data_in   = word(scn, first + i);
      strobe_in = 1'b1;
      step();
    end
    strobe_in = 1'b0;
  endtask

  task automatic wait_b(input int target);
    int n = 0;
    while ((b_cnt < target) && (n < 400)) begin
      step();
      n++;
    end
    if (b_cnt < target) check("b_timeout", 64'(b_cnt), 64'(target));
  endtask

  task automatic wait_fin();
    int n = 0;
    while (!finished && (n < 400)) begin
      step();
      n++;
    end
    if (!finished) check("fin_timeout", 64'(finished), 64'd1);
  endtask

  task automatic check_aw(input string tag, input int idx, input logic [AW-1:0] addr, input logic [3:0] len);
    if (idx < aw_addr_q.size()) begin
      check({tag, "_awaddr"}, 64'(aw_addr_q[idx]), 64'(addr));
      check({tag, "_awlen"}, 64'(aw_len_q[idx]), 64'(len));
    end else begin
      check({tag, "_aw_missing"}, 64'(aw_addr_q.size()), 64'(idx + 1));
    end
  endtask

  // Bursts are full except a final partial one, so wlast falls on every 16th beat and the final beat
  task automatic check_stream(input string tag, input int w_base, input int scn, input int n);
    check({tag, "_beats"}, 64'(w_data_q.size() - w_base), 64'(n));
    for (int k = 0; (k < n) && (w_base + k < w_data_q.size()); k++) begin
      check($sformatf("%s_data%0d", tag, k), w_data_q[w_base + k], word(scn, k));
      check($sformatf("%s_last%0d", tag, k), 64'(w_last_q[w_base + k]),
            64'(((k % 16) == 15) || (k == n - 1)));
    end
  endtask

  int ab, wb, bb, n;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; strobe_in = 1'b0; data_in = '0;
    start_address = '0; end_address = '0; aw_stall = 1'b0; bresp_val = 2'b00;
    step();
    step();
    check("rst_ctrl", 64'({awvalid, wvalid, wlast, bready, finished, dropped_samples, write_error}), 64'd0);
    check("rst_next", 64'(next_address), 64'd0);
    check("rst_aw", 64'({awaddr, awlen, awsize, awburst, awcache, awprot}), 64'd0);
    check("rst_w", {wdata}, 64'd0);
    check("rst_wstrb", 64'(wstrb), 64'd0);
    rst = 1'b0;
    step();

    // Full burst and first-burst latency
    ab = aw_addr_q.size(); wb = w_data_q.size(); bb = b_cnt;
    do_start(32'h1000, 32'h2000);
    push_words(1, 0, 16);
    check("s1_lat_cycle1", 64'(awvalid), 64'd0);
    step();
    check("s1_lat_cycle2", 64'(awvalid), 64'd1);
    check("s1_awaddr", 64'(awaddr), 64'h1000);
    check("s1_awlen", 64'(awlen), 64'd15);
    check("s1_fields", 64'({awsize, awburst, awcache, awprot}), 64'({3'd3, 2'b01, 4'b0011, 3'd0}));
    check("s1_wstrb", 64'(wstrb), 64'hFF);
    check("s1_no_w_before_aw", 64'(wvalid), 64'd0);
    step();
    check("s1_aw_drop", 64'(awvalid), 64'd0);
    check("s1_wvalid", 64'(wvalid), 64'd1);
    wait_b(bb + 1);
    step();
    check("s1_next", 64'(next_address), 64'h1080);
    check("s1_not_fin", 64'(finished), 64'd0);
    check("s1_aw_count", 64'(aw_addr_q.size() - ab), 64'd1);
    check_aw("s1_b0", ab, 32'h1000, 4'd15);
    check_stream("s1", wb, 1, 16);
    do_stop();
    wait_fin();
    check("s1_fin_next", 64'(next_address), 64'h1080);
    check("s1_fin_aw_count", 64'(aw_addr_q.size() - ab), 64'd1);

    // Stop flush with a partial burst; words after stop are discarded
    do_reset();
    ab = aw_addr_q.size(); wb = w_data_q.size();
    do_start(32'h1000, 32'h2000);
    push_words(2, 0, 21);
    do_stop();
    push_words(2, 100, 2);
    wait_fin();
    check("s2_fin", 64'(finished), 64'd1);
    check("s2_aw_count", 64'(aw_addr_q.size() - ab), 64'd2);
    check_aw("s2_b0", ab, 32'h1000, 4'd15);
    check_aw("s2_b1", ab + 1, 32'h1080, 4'd4);
    check_stream("s2", wb, 2, 21);
    check("s2_next", 64'(next_address), 64'h10A8);
    check("s2_no_drop", 64'(dropped_samples), 64'd0);

    // End limit stops recording
    do_reset();
    ab = aw_addr_q.size(); wb = w_data_q.size();
    do_start(32'h1000, 32'h1100);
    push_words(3, 0, 70);
    wait_fin();
    repeat (5) step();
    check("s3_fin", 64'(finished), 64'd1);
    check("s3_aw_count", 64'(aw_addr_q.size() - ab), 64'd2);
    check_aw("s3_b0", ab, 32'h1000, 4'd15);
    check_aw("s3_b1", ab + 1, 32'h1080, 4'd15);
    check("s3_next", 64'(next_address), 64'h1100);
    check("s3_awvalid_idle", 64'(awvalid), 64'd0);
    check_stream("s3", wb, 3, 32);

    // Overflow while the address channel is stalled
    do_reset();
    ab = aw_addr_q.size(); wb = w_data_q.size();
    aw_stall = 1'b1;
    do_start(32'h1000, 32'h2000);
    push_words(4, 0, 64);
    check("s4_no_drop_at_64", 64'(dropped_samples), 64'd0);
    check("s4_aw_held", 64'({awvalid, awaddr}), 64'({1'b1, 32'h1000}));
    push_words(4, 64, 1);
    check("s4_dropped", 64'(dropped_samples), 64'd1);
    aw_stall = 1'b0;
    do_stop();
    wait_fin();
    check("s4_aw_count", 64'(aw_addr_q.size() - ab), 64'd4);
    check_aw("s4_b0", ab, 32'h1000, 4'd15);
    check_aw("s4_b3", ab + 3, 32'h1180, 4'd15);
    check_stream("s4", wb, 4, 64);
    check("s4_next", 64'(next_address), 64'h1200);
    check("s4_drop_sticky", 64'(dropped_samples), 64'd1);

    // Error response is sticky and recording continues
    do_reset();
    ab = aw_addr_q.size(); bb = b_cnt;
    bresp_val = 2'b10;
    do_start(32'h1000, 32'h2000);
    push_words(5, 0, 32);
    n = 0;
    while (!write_error && (n < 100)) begin
      step();
      n++;
    end
    bresp_val = 2'b00;
    check("s5_err_set", 64'(write_error), 64'd1);
    check("s5_err_on_first", 64'(b_cnt - bb), 64'd1);
    wait_b(bb + 2);
    step();
    check("s5_err_sticky", 64'(write_error), 64'd1);
    check_aw("s5_b1", ab + 1, 32'h1080, 4'd15);
    do_stop();
    wait_fin();
    check("s5_next", 64'(next_address), 64'h1100);
    check("s5_err_final", 64'(write_error), 64'd1);

`ifdef RECORDER_WRAP_EN
    // Ring-buffer wrap
    do_reset();
    ab = aw_addr_q.size(); wb = w_data_q.size(); bb = b_cnt;
    do_start(32'h1000, 32'h1100);
    push_words(6, 0, 48);
    wait_b(bb + 3);
    step();
    check("s6_aw_count", 64'(aw_addr_q.size() - ab), 64'd3);
    check_aw("s6_b2", ab + 2, 32'h1000, 4'd15);
    check("s6_wrapped", 64'(wrapped), 64'd1);
    check("s6_next", 64'(next_address), 64'h1080);
    check("s6_not_fin", 64'(finished), 64'd0);
    do_stop();
    wait_fin();
    check_stream("s6", wb, 6, 48);
`endif

    // Reset in the middle of a data phase
    do_reset();
    do_start(32'h1000, 32'h2000);
    push_words(7, 0, 18);
    n = 0;
    while (!wvalid && (n < 40)) begin
      step();
      n++;
    end
    check("s7_in_data", 64'(wvalid), 64'd1);
    rst = 1'b1;
    step();
    check("s7_rst_ctrl", 64'({awvalid, wvalid, wlast, bready, finished}), 64'd0);
    check("s7_rst_next", 64'(next_address), 64'd0);
    rst = 1'b0;
    repeat (3) step();
    check("s7_idle", 64'({awvalid, wvalid}), 64'd0);

    check("protocol", 64'(proto_err), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/recorder_burst_writer.md
Name: recorder_burst_writer

Overview:
- Single-clock successor to the recorder's DDR write path.
- Accepts a packed sample-word stream with no backpressure and buffers it in an internal FIFO.
- Writes the stream to memory as AXI3 write bursts between a configurable start and end address.
- Adds over the previous generation: parametrised data width, burst length and FIFO depth; partial-burst flush on stop; sticky write-error reporting; optional ring-buffer recording.

Parameters:
- DATA_WIDTH, 64, word width in bits; 32 or 64.
- BURST_BEATS, 16, beats per full burst; 2..16.
- FIFO_DEPTH, 64, internal FIFO words; power of two, >= 2*BURST_BEATS.
- ADDR_WIDTH, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_in  in  DATA_WIDTH  packed sample word
- strobe_in  in  1  data_in valid; no backpressure
- start  in  1  pulse: begin recording
- stop  in  1  pulse: end recording
- start_address  in  ADDR_WIDTH  first byte address; aligned to BURST_BEATS*DATA_WIDTH/8
- end_address  in  ADDR_WIDTH  exclusive limit; same alignment
- finished  out  1  recording complete
- dropped_samples  out  1  sticky: word lost to a full FIFO
- write_error  out  1  sticky: BRESP != OKAY seen
- next_address  out  ADDR_WIDTH  address after the last completed burst
- awaddr/awlen[3:0]/awsize[2:0]/awburst[1:0]/awcache[3:0]/awprot[2:0]/awvalid  out  AXI3 AW channel
- awready  in  1
- wdata[DATA_WIDTH]/wstrb[DATA_WIDTH/8]/wlast/wvalid  out  AXI3 W channel
- wready  in  1
- bresp  in  2
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM IDLE.
- Fixed field values: awburst=INCR, awsize=log2(DATA_WIDTH/8), awcache=4'b0011, awprot=0, wstrb all ones.
- FSM states: IDLE, WAIT, ADDR, DATA, RESP, DONE.
- IDLE:
  - FIFO held empty; strobe_in ignored.
  - start: load cur=start_address and next_address=start_address; clear finished, dropped_samples, write_error; go to WAIT.
- WAIT:
  - FIFO level >= BURST_BEATS: burst length n=BURST_BEATS, go to ADDR.
  - Stop pending and level>0: n=level, go to ADDR.
  - Stop pending and level=0: go to DONE.
- ADDR:
  - awvalid=1, awaddr=cur, awlen=n-1. These hold stable until awready.
  - Then go to DATA. awvalid falls the cycle after the handshake.
- DATA:
  - wvalid=1; wdata is the FIFO head; a pop occurs on wvalid&wready.
  - wlast=1 on beat n.
  - After the last beat, go to RESP.
  - W is never asserted before the AW handshake.
- RESP:
  - bready=1.
  - On bvalid: cur+=n*DATA_WIDTH/8; next_address=cur; bresp!=0 sets write_error.
  - If cur==end_address, go to DONE; else go to WAIT.
- DONE: finished=1 held until the next start; recording stops.
- Single outstanding burst at any time.
- FIFO behaviour:
  - Writes on strobe_in in WAIT/ADDR/DATA/RESP.
  - A write while full drops the word and sets dropped_samples.
  - Simultaneous push and pop on a full FIFO is accepted, no drop.
  - Words arriving after stop is registered are discarded, not counted as dropped.
- stop handling:
  - Registered as a pending flag in any active state.
  - Never aborts a burst in progress.
  - stop in IDLE/DONE is ignored.
  - start while active is ignored.
  - Simultaneous start and stop in IDLE: start wins, stop is registered as pending.
- Partial bursts occur only on flush. Alignment guarantees no 4 KiB crossing.
- Reset mid-burst: all outputs drop to 0 next cycle with no completion of the AXI transaction. The interconnect is reset together with this block.
- Latency: first awvalid occurs 2 cycles after the BURST_BEATS-th word is pushed.

Optional Feature:
- Macro: RECORDER_WRAP_EN.
- With the macro: when cur reaches end_address, cur reloads start_address and recording continues until stop. A sticky output wrapped (1 bit, reset 0, cleared on start) is added and set on the first wrap. next_address then reports the wrapped value.
- Without the macro: reaching end_address goes to DONE, and the wrapped port does not exist.

Test Plan:
- Scenario 1, full burst:
  - Stimulus: start_address=0x1000, end_address=0x2000, 16 strobes, always-ready slave.
  - Response: one burst with awaddr=0x1000 and awlen=15; wdata in order; wlast on beat 16; next_address=0x1080.
- Scenario 2, stop flush:
  - Stimulus: 21 words, then stop.
  - Response: bursts with awlen=15 then awlen=4 at 0x1080; finished=1; next_address=0x10A8.
- Scenario 3, end limit:
  - Stimulus: end_address=0x1100, continuous strobes.
  - Response: exactly 2 bursts, then finished=1 and next_address=0x1100; no further awvalid.
- Scenario 4, overflow:
  - Stimulus: awready held 0 while 65 words are pushed.
  - Response: dropped_samples=1; the first 64 words are written intact and in order after awready is released.
- Scenario 5, error response:
  - Stimulus: bresp=2'b10 on the first burst.
  - Response: write_error=1 and stays set; recording continues.
- Scenario 6, RECORDER_WRAP_EN:
  - Stimulus: window 0x1000..0x1100, 48 words.
  - Response: third burst at awaddr=0x1000; wrapped=1; next_address=0x1080.
